// File: rtl/pipeline_hazard_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller_if
// Description : Stage-field bus between the datapath and the hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_controller_if;
    logic [5:0] Dopcode;
    logic [3:0] Daddress1;
    logic [3:0] Daddress2;
    logic [5:0] Eopcode;
    logic [3:0] Ewrite_addr;
    logic       Ereg_write;
    logic [3:0] Mwrite_addr;
    logic       Mreg_write;
    logic       Ejump_taken;
    logic       Fstall;
    logic       Dstall;
    logic       FDflush;
    logic       Eflush;
    logic [1:0] fwdA;
    logic [1:0] fwdB;
    logic       busy;

    modport master (
        output Dopcode, Daddress1, Daddress2, Eopcode, Ewrite_addr, Ereg_write,
               Mwrite_addr, Mreg_write, Ejump_taken,
        input  Fstall, Dstall, FDflush, Eflush, fwdA, fwdB, busy
    );

    modport slave (
        input  Dopcode, Daddress1, Daddress2, Eopcode, Ewrite_addr, Ereg_write,
               Mwrite_addr, Mreg_write, Ejump_taken,
        output Fstall, Dstall, FDflush, Eflush, fwdA, fwdB, busy
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller
// Description : Load-use / multiply stall FSM, jump flush and operand
//               forwarding selects. HAZARD_PERF_COUNT_EN adds stall/flush
//               event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller #(
    parameter logic [5:0] LOAD_OPCODE = 6'b010000,
    parameter logic [5:0] MUL_OPCODE  = 6'b001100,
    parameter int         MUL_LATENCY = 3
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    pipeline_hazard_controller_if.slave   hz
`ifdef HAZARD_PERF_COUNT_EN
    ,
    output logic [15:0]                   stall_count,
    output logic [15:0]                   flush_count
`endif
);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_LOAD_STALL = 2'd1;
    localparam logic [1:0] S_MUL_BUSY   = 2'd2;

    localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LATENCY - 2);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic load_use;
    logic mul_start;
    logic f_stall, d_stall, fd_flush, e_flush;
    logic [1:0] fwd_a, fwd_b;

    // The decode opcode is on the watched bus but no hazard depends on it.
    logic dopcode_unused;
    assign dopcode_unused = ^hz.Dopcode;

    assign load_use  = (hz.Eopcode == LOAD_OPCODE) && hz.Ereg_write &&
                       ((hz.Ewrite_addr == hz.Daddress1) ||
                        (hz.Ewrite_addr == hz.Daddress2));
    assign mul_start = (hz.Eopcode == MUL_OPCODE) && !load_use;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (hz.Ejump_taken) begin
                    state_d = S_IDLE;
                end else if (load_use) begin
                    state_d = S_LOAD_STALL;
                end else if (mul_start) begin
                    state_d = S_MUL_BUSY;
                    cnt_d   = MUL_CNT_INIT;
                end
            end
            S_LOAD_STALL: begin
                state_d = S_IDLE;
            end
            S_MUL_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output logic; execute holds the multiply during MUL_BUSY so a jump cannot occur there
    always_comb begin
        f_stall  = 1'b0;
        d_stall  = 1'b0;
        fd_flush = 1'b0;
        e_flush  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hz.Ejump_taken) begin
                    fd_flush = 1'b1;
                    e_flush  = 1'b1;
                end else if (load_use || mul_start) begin
                    f_stall = 1'b1;
                    d_stall = 1'b1;
                    e_flush = 1'b1;
                end
            end
            S_LOAD_STALL: begin
                if (hz.Ejump_taken) begin
                    fd_flush = 1'b1;
                    e_flush  = 1'b1;
                end
            end
            S_MUL_BUSY: begin
                f_stall = 1'b1;
                d_stall = 1'b1;
                e_flush = 1'b1;
            end
            default: begin
                f_stall = 1'b0;
            end
        endcase
    end

    // A load result is not ready in execute, so only ALU results forward from there
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (hz.Ereg_write && (hz.Ewrite_addr == hz.Daddress1) &&
            (hz.Eopcode != LOAD_OPCODE)) begin
            fwd_a = 2'b01;
        end else if (hz.Mreg_write && (hz.Mwrite_addr == hz.Daddress1)) begin
            fwd_a = 2'b10;
        end
        if (hz.Ereg_write && (hz.Ewrite_addr == hz.Daddress2) &&
            (hz.Eopcode != LOAD_OPCODE)) begin
            fwd_b = 2'b01;
        end else if (hz.Mreg_write && (hz.Mwrite_addr == hz.Daddress2)) begin
            fwd_b = 2'b10;
        end
    end

    // Outputs are forced low for as long as reset is held, independent of the clock
    assign hz.Fstall  = reset & f_stall;
    assign hz.Dstall  = reset & d_stall;
    assign hz.FDflush = reset & fd_flush;
    assign hz.Eflush  = reset & e_flush;
    assign hz.fwdA    = reset ? fwd_a : 2'b00;
    assign hz.fwdB    = reset ? fwd_b : 2'b00;
    assign hz.busy    = reset & (state_q != S_IDLE);

`ifdef HAZARD_PERF_COUNT_EN
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_q <= 16'd0;
            flush_count_q <= 16'd0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (d_stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
        if (fd_flush && (flush_count_q != 16'hFFFF)) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_controller
// Description : Vector-table and scoreboard bench for the hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

    localparam logic [5:0] LD = 6'b010000;
    localparam logic [5:0] MU = 6'b001100;
    localparam logic [5:0] AD = 6'b100000;
    localparam int NVEC = 20;

    typedef struct {
        logic [5:0] eop;
        logic [3:0] d1;
        logic [3:0] d2;
        logic [3:0] ewa;
        logic       ereg;
        logic [3:0] mwa;
        logic       mreg;
        logic       jmp;
        logic [8:0] exp;   // {Fstall,Dstall,FDflush,Eflush,fwdA,fwdB,busy}
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_controller_if bus ();

`ifdef HAZARD_PERF_COUNT_EN
    logic [15:0] stall_count;
    logic [15:0] flush_count;
`endif

    pipeline_hazard_controller #(
        .LOAD_OPCODE (LD),
        .MUL_OPCODE  (MU),
        .MUL_LATENCY (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (bus.slave)
`ifdef HAZARD_PERF_COUNT_EN
        ,
        .stall_count (stall_count),
        .flush_count (flush_count)
`endif
    );

    vec_t       vecs [NVEC];
    logic [8:0] sb_q [$];
    int         checks = 0;
    int         errors = 0;

    wire [8:0] out_vec = {bus.Fstall, bus.Dstall, bus.FDflush, bus.Eflush,
                          bus.fwdA, bus.fwdB, bus.busy};

    function automatic vec_t mk(logic [5:0] eop, logic [3:0] d1, logic [3:0] d2,
                                logic [3:0] ewa, logic ereg, logic [3:0] mwa,
                                logic mreg, logic jmp, logic [8:0] exp);
        vec_t v;
        v.eop = eop; v.d1 = d1; v.d2 = d2; v.ewa = ewa; v.ereg = ereg;
        v.mwa = mwa; v.mreg = mreg; v.jmp = jmp; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.Dopcode     = 6'd0;
        bus.Eopcode     = v.eop;
        bus.Daddress1   = v.d1;
        bus.Daddress2   = v.d2;
        bus.Ewrite_addr = v.ewa;
        bus.Ereg_write  = v.ereg;
        bus.Mwrite_addr = v.mwa;
        bus.Mreg_write  = v.mreg;
        bus.Ejump_taken = v.jmp;
    endtask

    task automatic apply(input vec_t v, input string name);
        logic [8:0] e;
        @(posedge clk);
        #1;
        drive(v);
        sb_q.push_back(v.exp);
        @(negedge clk);
        e = sb_q.pop_front();
        check(name, 32'(out_vec), 32'(e));
    endtask

    initial begin
        vec_t quiet;
        quiet = mk(AD, 4'd1, 4'd2, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 9'b0);

        vecs[0]  = quiet;
        vecs[1]  = mk(AD, 4'd1, 4'd5, 4'd5, 1'b1, 4'd5, 1'b1, 1'b0, 9'b0000_00_01_0);
        vecs[2]  = mk(AD, 4'd1, 4'd5, 4'd5, 1'b0, 4'd5, 1'b1, 1'b0, 9'b0000_00_10_0);
        vecs[3]  = mk(AD, 4'd1, 4'd5, 4'd5, 1'b0, 4'd5, 1'b0, 1'b0, 9'b0000_00_00_0);
        vecs[4]  = mk(AD, 4'd7, 4'd2, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0, 9'b0000_01_00_0);
        vecs[5]  = mk(AD, 4'd0, 4'd2, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 9'b0000_01_00_0);
        vecs[6]  = mk(LD, 4'd3, 4'd2, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 9'b1101_00_00_0);
        vecs[7]  = mk(AD, 4'd3, 4'd2, 4'd9, 1'b0, 4'd3, 1'b1, 1'b0, 9'b0000_10_00_1);
        vecs[8]  = quiet;
        vecs[9]  = mk(LD, 4'd1, 4'd4, 4'd4, 1'b1, 4'd0, 1'b0, 1'b0, 9'b1101_00_00_0);
        vecs[10] = mk(AD, 4'd1, 4'd4, 4'd9, 1'b0, 4'd4, 1'b1, 1'b0, 9'b0000_00_10_1);
        vecs[11] = mk(LD, 4'd3, 4'd2, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 9'b0000_00_00_0);
        vecs[12] = mk(LD, 4'd3, 4'd2, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 9'b0011_00_00_0);
        vecs[13] = quiet;
        vecs[14] = mk(MU, 4'd1, 4'd2, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 9'b1101_00_00_0);
        vecs[15] = mk(MU, 4'd1, 4'd2, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 9'b1101_00_00_1);
        vecs[16] = mk(MU, 4'd1, 4'd2, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 9'b1101_00_00_1);
        vecs[17] = quiet;
        vecs[18] = mk(AD, 4'd1, 4'd2, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 9'b0011_00_00_0);
        vecs[19] = quiet;

        // Hazardous inputs while in reset: every output must still read 0
        drive(mk(MU, 4'd5, 4'd5, 4'd5, 1'b1, 4'd5, 1'b1, 1'b1, 9'b0));
        #7;
        check("in_reset", 32'(out_vec), 32'd0);
        drive(quiet);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("after_release", 32'(out_vec), 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Async reset dropped between edges while the multiply is in MUL_BUSY
        apply(vecs[14], "rst_mul_start");
        @(posedge clk);
        #1;
        check("rst_mul_busy", 32'(out_vec), 32'(9'b1101_00_00_1));
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_mul", 32'(out_vec), 32'd0);
        drive(quiet);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("post_rst%0d", i), 32'(out_vec), 32'd0);
        end

`ifdef HAZARD_PERF_COUNT_EN
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("perf_rst_stall", 32'(stall_count), 32'd0);
        check("perf_rst_flush", 32'(flush_count), 32'd0);
        reset = 1'b1;
        apply(vecs[6],  "perf_load");
        apply(vecs[7],  "perf_load_stall");
        apply(vecs[14], "perf_mul0");
        apply(vecs[15], "perf_mul1");
        apply(vecs[16], "perf_mul2");
        apply(vecs[17], "perf_quiet0");
        apply(vecs[18], "perf_jump0");
        apply(vecs[19], "perf_quiet1");
        apply(vecs[18], "perf_jump1");
        apply(vecs[19], "perf_quiet2");
        check("stall_count", 32'(stall_count), 32'd4);
        check("flush_count", 32'(flush_count), 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
